// File: rtl/seg7_reader.sv
// Seven-segment pattern reader: debounces an active-low segment bus, decodes
// settled patterns to hex digits and delivers them over a valid/ready handshake.
// Blank (all segments off) and illegal patterns are reported separately.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    output logic [3:0] hex_out,
    output logic       hex_valid,
    input  logic       hex_ready,
    output logic       blank,
    output logic       pat_err,
    output logic       overrun,
    output logic [7:0] err_count
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [6:0] BLANK_PAT  = 7'h7F;

    typedef enum logic {
        IDLE,
        OUT
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [6:0] seg_q;
    logic [7:0] stab_cnt;
    logic       accept_q;
    logic       code_legal;
    logic [3:0] code_digit;
    logic       is_blank;
    logic       emit;
    logic       handshake;
    logic       load;
    logic       drop;
    logic [3:0] last_digit;
    logic       last_valid;

    // Sample the bus and count how long it has stayed unchanged; flag the one
    // cycle in which the count reaches the settle threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q    <= BLANK_PAT;
            stab_cnt <= 8'd0;
            accept_q <= 1'b0;
        end else begin
            seg_q <= seg_in;
            if (seg_in != seg_q) begin
                stab_cnt <= 8'd0;
            end else if (stab_cnt != STABLE_MAX) begin
                stab_cnt <= stab_cnt + 8'd1;
            end
            accept_q <= (seg_in == seg_q) && (stab_cnt == STABLE_MAX - 8'd1);
        end
    end

    // Decode the settled pattern into a hex digit, if it is a legal code.
    always_comb begin
        code_legal = 1'b1;
        code_digit = 4'h0;
        case (seg_q)
            7'h40:   code_digit = 4'h0;
            7'h79:   code_digit = 4'h1;
            7'h24:   code_digit = 4'h2;
            7'h30:   code_digit = 4'h3;
            7'h19:   code_digit = 4'h4;
            7'h12:   code_digit = 4'h5;
            7'h02:   code_digit = 4'h6;
            7'h78:   code_digit = 4'h7;
            7'h00:   code_digit = 4'h8;
            7'h10:   code_digit = 4'h9;
            7'h08:   code_digit = 4'hA;
            7'h03:   code_digit = 4'hB;
            7'h46:   code_digit = 4'hC;
            7'h21:   code_digit = 4'hD;
            7'h06:   code_digit = 4'hE;
            7'h0E:   code_digit = 4'hF;
            default: code_legal = 1'b0;
        endcase
    end

    assign is_blank  = (seg_q == BLANK_PAT);
    assign emit      = accept_q && code_legal &&
                       (!last_valid || (code_digit != last_digit));
    assign handshake = (state == OUT) && hex_ready;
    assign hex_valid = (state == OUT);

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Decide whether a new digit is loaded, dropped, or the output is released.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (emit) begin
                    load       = 1'b1;
                    next_state = OUT;
                end
            end
            OUT: begin
                if (handshake) begin
                    if (emit) begin
                        load = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (emit) begin
                    drop = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output digit, repeat-suppression memory and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_out    <= 4'h0;
            last_digit <= 4'h0;
            last_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                hex_out    <= code_digit;
                last_digit <= code_digit;
                last_valid <= 1'b1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
            if (accept_q && is_blank) begin
                last_valid <= 1'b0;
            end
        end
    end

    // Blank level, illegal-pattern pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank     <= 1'b0;
            pat_err   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            pat_err <= 1'b0;
            if (accept_q) begin
                if (is_blank) begin
                    blank <= 1'b1;
                end else if (code_legal) begin
                    blank <= 1'b0;
                end else begin
                    blank   <= 1'b0;
                    pat_err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: a run-length based reference model is
// compared every cycle, and directed scenarios pin literal expectations.
module tb_seg7_reader;

    localparam int STABLE = 4;
    localparam logic [6:0] CODE_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clock;
    logic       reset;
    logic [6:0] segIn;
    logic [3:0] hexOut;
    logic       hexValid;
    logic       hexReady;
    logic       blank;
    logic       patErr;
    logic       overrun;
    logic [7:0] errCount;

    int checks = 0;
    int errors = 0;
    bit modelOn = 0;

    int nValid;
    int nPatErr;
    bit sawF;

    logic [6:0] mHeld;
    int         mRun;
    bit         mPend;
    logic [6:0] mPendVal;
    logic [3:0] mHexOut;
    bit         mValid;
    bit         mBlank;
    bit         mPatErr;
    bit         mOverrun;
    int         mErr;
    bit         mLastValid;
    logic [3:0] mLast;

    seg7_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clk      (clock),
        .reset    (reset),
        .seg_in   (segIn),
        .hex_out  (hexOut),
        .hex_valid(hexValid),
        .hex_ready(hexReady),
        .blank    (blank),
        .pat_err  (patErr),
        .overrun  (overrun),
        .err_count(errCount)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int codeIndex(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (CODE_TABLE[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a pattern is taken once it has been seen on STABLE+1
    // consecutive edges; its effect on the outputs appears one edge later.
    always @(posedge clock) begin : refModel
        logic [6:0] nHeld;
        int         nRun;
        bit         nPend;
        logic [3:0] nHexOut;
        bit         nValid;
        bit         nBlank;
        bit         nPatErrV;
        bit         nOverrun;
        int         nErr;
        bit         nLastValid;
        logic [3:0] nLast;
        bit         handshakeNow;
        bit         emitNow;
        int         idx;
        if (reset) begin
            mHeld      <= 7'h7F;
            mRun       <= 1;
            mPend      <= 0;
            mPendVal   <= 7'h7F;
            mHexOut    <= 4'h0;
            mValid     <= 0;
            mBlank     <= 0;
            mPatErr    <= 0;
            mOverrun   <= 0;
            mErr       <= 0;
            mLastValid <= 0;
            mLast      <= 4'h0;
        end else begin
            nHexOut = mHexOut; nValid = mValid; nBlank = mBlank; nOverrun = mOverrun;
            nErr = mErr; nLastValid = mLastValid; nLast = mLast;
            nPatErrV = 0;
            emitNow = 0;
            idx = -1;
            handshakeNow = mValid && hexReady;
            if (mPend) begin
                idx = codeIndex(mPendVal);
                if (mPendVal == 7'h7F) begin
                    nBlank = 1;
                    nLastValid = 0;
                end else if (idx >= 0) begin
                    nBlank = 0;
                    if (!mLastValid || idx != int'(mLast)) emitNow = 1;
                end else begin
                    nBlank = 0;
                    nPatErrV = 1;
                    if (nErr < 255) nErr++;
                end
            end
            if (emitNow) begin
                if (!mValid || handshakeNow) begin
                    nHexOut = 4'(idx);
                    nValid = 1;
                    nLast = 4'(idx);
                    nLastValid = 1;
                end else begin
                    nOverrun = 1;
                end
            end else if (handshakeNow) begin
                nValid = 0;
            end
            if (segIn == mHeld) nRun = mRun + 1;
            else nRun = 1;
            nHeld = segIn;
            nPend = (nRun == STABLE + 1);
            mHeld      <= nHeld;
            mRun       <= nRun;
            mPend      <= nPend;
            mPendVal   <= segIn;
            mHexOut    <= nHexOut;
            mValid     <= nValid;
            mBlank     <= nBlank;
            mPatErr    <= nPatErrV;
            mOverrun   <= nOverrun;
            mErr       <= nErr;
            mLastValid <= nLastValid;
            mLast      <= nLast;
        end
    end

    // Every-cycle comparison of the DUT against the reference model.
    always @(negedge clock) begin
        if (modelOn) begin
            checkOutput("hex_valid", int'(hexValid), int'(mValid));
            checkOutput("hex_out", int'(hexOut), int'(mHexOut));
            checkOutput("blank", int'(blank), int'(mBlank));
            checkOutput("pat_err", int'(patErr), int'(mPatErr));
            checkOutput("overrun", int'(overrun), int'(mOverrun));
            checkOutput("err_count", int'(errCount), mErr);
        end
    end

    task automatic tick();
        @(negedge clock);
        if (hexValid) nValid++;
        if (patErr) nPatErr++;
        if (hexValid && hexOut == 4'hF) sawF = 1;
    endtask

    task automatic applyStimulus(input logic [6:0] pat, input logic ready, input int cycles);
        segIn = pat;
        hexReady = ready;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic resetDut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic measureLatency(input logic [6:0] pat, input int expEdge, input int expDigit);
        int firstEdge;
        int digit;
        firstEdge = -1;
        digit = -1;
        reset = 1'b0;
        segIn = pat;
        hexReady = 1'b1;
        nValid = 0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (hexValid && firstEdge < 0) begin
                firstEdge = e;
                digit = int'(hexOut);
            end
        end
        checkOutput("latency_edge", firstEdge, expEdge);
        checkOutput("latency_digit", digit, expDigit);
        checkOutput("latency_pulses", nValid, 1);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        segIn = 7'h7F;
        hexReady = 1'b1;
        nValid = 0; nPatErr = 0; sawF = 0;
        @(negedge clock);
        modelOn = 1;
        tick();

        // Held legal code: one digit 2 on the sixth edge, no repeat.
        measureLatency(7'h24, 6, 2);

        // Toggling too fast to settle: nothing delivered, no errors.
        nValid = 0; nPatErr = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(7'h40, 1'b1, 2);
            applyStimulus(7'h79, 1'b1, 2);
        end
        checkOutput("toggle_valid", nValid, 0);
        checkOutput("toggle_pat_err", nPatErr, 0);

        // Illegal pattern, then saturation of the error counter.
        resetDut();
        nValid = 0; nPatErr = 0;
        applyStimulus(7'h55, 1'b1, 8);
        checkOutput("illegal_pulses", nPatErr, 1);
        checkOutput("illegal_count", int'(errCount), 1);
        checkOutput("illegal_valid", nValid, 0);
        for (int k = 0; k < 300; k++) begin
            applyStimulus((k % 2 == 0) ? 7'h2A : 7'h55, 1'b1, 6);
        end
        checkOutput("err_saturate", int'(errCount), 255);

        // Consumer stalled: second digit dropped, overrun raised.
        resetDut();
        sawF = 0;
        applyStimulus(7'h12, 1'b0, 8);
        applyStimulus(7'h0E, 1'b0, 8);
        checkOutput("stall_hex_out", int'(hexOut), 5);
        checkOutput("stall_valid", int'(hexValid), 1);
        checkOutput("stall_overrun", int'(overrun), 1);
        applyStimulus(7'h0E, 1'b1, 3);
        checkOutput("release_valid", int'(hexValid), 0);
        checkOutput("never_F", int'(sawF), 0);

        // Blank between two identical digits re-enables the repeat.
        resetDut();
        nValid = 0;
        applyStimulus(7'h30, 1'b1, 8);
        checkOutput("blank_seg1", int'(blank), 0);
        applyStimulus(7'h7F, 1'b1, 8);
        checkOutput("blank_seg2", int'(blank), 1);
        applyStimulus(7'h30, 1'b1, 8);
        checkOutput("blank_seg3", int'(blank), 0);
        checkOutput("blank_digits", nValid, 2);
        checkOutput("blank_hex_out", int'(hexOut), 3);

        // Reset in the middle of settling.
        resetDut();
        applyStimulus(7'h24, 1'b1, 3);
        reset = 1'b1;
        tick();
        checkOutput("rst_settle_valid", int'(hexValid), 0);
        checkOutput("rst_settle_hex", int'(hexOut), 0);
        measureLatency(7'h24, 6, 2);

        // Reset while a digit is pending and errors have been counted.
        applyStimulus(7'h12, 1'b0, 8);
        checkOutput("pending_valid", int'(hexValid), 1);
        applyStimulus(7'h55, 1'b0, 8);
        checkOutput("pending_err", int'(errCount), 1);
        reset = 1'b1;
        tick();
        checkOutput("rst_out_valid", int'(hexValid), 0);
        checkOutput("rst_out_hex", int'(hexOut), 0);
        checkOutput("rst_out_err", int'(errCount), 0);
        checkOutput("rst_out_overrun", int'(overrun), 0);
        checkOutput("rst_out_blank", int'(blank), 0);
        checkOutput("rst_out_pat_err", int'(patErr), 0);
        measureLatency(7'h24, 6, 2);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive equal samples (after the first) required before a pattern is accepted; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port seg_in  input  7  active-low segment pattern, bit0=a .. bit6=g.
REQ-005 SHALL have port hex_out  output  4  decoded hex digit.
REQ-006 SHALL have port hex_valid  output  1  hex_out holds an undelivered digit.
REQ-007 SHALL have port hex_ready  input  1  consumer accepts digit when hex_valid && hex_ready.
REQ-008 SHALL have port blank  output  1  level; last accepted pattern was 7'h7F.
REQ-009 SHALL have port pat_err  output  1  one-cycle pulse; accepted pattern is not a legal code.
REQ-010 SHALL have port overrun  output  1  sticky; a digit was dropped because hex_valid was still high.
REQ-011 SHALL have port err_count  output  8  count of pat_err pulses, saturating at 255.

Function
REQ-012 SHALL register seg_in into seg_q each cycle; all decisions use seg_q, never seg_in directly.
REQ-013 SHALL keep an 8-bit stab_cnt: cleared when seg_in != seg_q, else incremented, saturating at STABLE_CYCLES.
REQ-014 SHALL accept seg_q exactly once, in the cycle stab_cnt transitions to STABLE_CYCLES; no re-acceptance until seg_in changes.
REQ-015 SHALL map legal codes to digits: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F (hex of seg bits 6:0).
REQ-016 SHALL treat 7'h7F as blank: set blank=1, emit no digit, no pat_err, and clear last-digit memory.
REQ-017 SHALL treat any other accepted pattern as illegal: pat_err=1 for one cycle, err_count+1 (saturating), blank=0, no digit.
REQ-018 SHALL, on a legal accepted code, clear blank and emit a digit only if it differs from last emitted digit or last-digit memory is empty.
REQ-019 SHALL implement FSM IDLE/OUT: IDLE->OUT on digit emission (hex_out loaded, hex_valid=1); OUT->IDLE on the cycle hex_valid && hex_ready (hex_valid=0 next cycle).
REQ-020 SHALL hold hex_out and hex_valid constant in OUT until handshake completes.
REQ-021 SHALL, if a digit emission occurs while in OUT and handshake does not complete that same cycle, drop the new digit, set overrun=1, leave hex_out unchanged, and not update last-digit memory.
REQ-022 SHALL, if emission coincides with handshake completion in OUT, load the new digit and keep hex_valid=1 (back-to-back, no overrun).
REQ-023 SHALL keep stab_cnt tracking in both FSM states; blank/pat_err/err_count updates are independent of FSM state.
REQ-024 SHALL produce hex_valid on the rising edge following the (STABLE_CYCLES+1)th consecutive edge sampling P on seg_in, given IDLE.
REQ-025 SHALL drive all outputs from registers (no combinational path from seg_in or hex_ready to any output).

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set: seg_q=7'h7F, stab_cnt=0, FSM=IDLE, hex_out=0, hex_valid=0, blank=0, pat_err=0, overrun=0, err_count=0, last-digit memory empty.
REQ-027 SHALL let reset override any in-progress handshake or settle count; pending digit is discarded.
REQ-028 SHALL accept nothing while reset is high; the first post-reset acceptance requires full STABLE_CYCLES settling.

Verification
REQ-029 Bench SHALL cover: STABLE_CYCLES=4, hex_ready=1, seg_in=7'h24 held 10 cycles -> one hex_valid pulse, hex_out=2, on edge 6 after first sample; no repeat.
REQ-030 Bench SHALL cover: seg_in toggles 7'h40/7'h79 every 2 cycles for 20 cycles -> hex_valid never asserts, stab_cnt never reaches 4.
REQ-031 Bench SHALL cover: seg_in=7'h55 held 8 cycles -> one pat_err pulse, err_count=1, hex_valid=0; repeat 300 distinct illegal episodes -> err_count=255.
REQ-032 Bench SHALL cover: hex_ready=0, 7'h12 then 7'h0E each held 8 cycles -> hex_out=5 held, overrun=1; then hex_ready=1 -> hex_valid drops, digit F never appears.
REQ-033 Bench SHALL cover: 7'h30 (8 cyc), 7'h7F (8 cyc), 7'h30 (8 cyc), hex_ready=1 -> two digits 3, blank=1 during middle segment only.
REQ-034 Bench SHALL cover: reset asserted mid-settle and while hex_valid=1 -> all outputs at REQ-026 values next edge; same pattern re-settles from zero afterward.
